// File: rtl/simon_pkg.sv
// Shared types and timing helpers for the sequence player.
package simon_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_ON    = 3'd3,
      S_OFF   = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   localparam int unsigned DEF_ON_CYC  = 32'd25_000_000;
   localparam int unsigned DEF_OFF_CYC = 32'd25_000_000;
   localparam int unsigned DEF_DEC_CYC = 32'd2_000_000;
   localparam int unsigned DEF_MIN_CYC = 32'd5_000_000;

   // Period shrinks by level*dec but never drops below min_cyc and never wraps.
   function automatic logic [31:0] period_f(input logic [31:0] base,
                                            input logic [31:0] level,
                                            input logic [31:0] dec,
                                            input logic [31:0] min_cyc);
      logic [31:0] cut;
      cut = level * dec;
      if (cut >= base) begin
         return min_cyc;
      end else if ((base - cut) < min_cyc) begin
         return min_cyc;
      end else begin
         return base - cut;
      end
   endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Channel index to one-hot LED pattern; indices at or above N_CH decode to all zeros.
module onehot_decoder #(
   parameter int N_CH  = 4,
   parameter int OUT_W = 10,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic [SEL_W-1:0] sel_i,
   output logic [OUT_W-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_i == SEL_W'(i)) begin
            onehot_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_player.sv
// Plays a stored colour sequence on the LED bus with level-dependent on/off periods.
//
//  state | meaning
//  IDLE  | waiting for start; outputs quiet, step index 0
//  FETCH | read strobe to sequence memory at the current step
//  WAIT  | memory data valid; decode and light the LED on exit
//  ON    | LED lit for on_len cycles
//  OFF   | all dark for off_len cycles, then next step or finish
//  DONE  | one-cycle done pulse, busy already low
module seq_player
   import simon_pkg::*;
#(
   parameter int          N_CH    = 4,
   parameter int          ADDR_W  = 4,
   parameter int          LVL_W   = 4,
   parameter int          OUT_W   = 10,
   parameter int unsigned ON_CYC  = DEF_ON_CYC,
   parameter int unsigned OFF_CYC = DEF_OFF_CYC,
   parameter int unsigned DEC_CYC = DEF_DEC_CYC,
   parameter int unsigned MIN_CYC = DEF_MIN_CYC,
   parameter int          SEL_W   = $clog2(N_CH)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [ADDR_W:0]   length_i,
   input  logic [LVL_W-1:0]  level_i,
   output logic              mem_rd_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [SEL_W-1:0]  mem_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W:0]   step_o,
   output logic [OUT_W-1:0]  led_out_o
);

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   state_e            state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic [31:0]       on_q, on_d;
   logic [31:0]       off_q, off_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [OUT_W-1:0]  led_q, led_d;

   logic [OUT_W-1:0]  dec_oh;
   logic [ADDR_W:0]   len_eff;
   logic [31:0]       on_load, off_load;

   onehot_decoder #(
      .N_CH  (N_CH),
      .OUT_W (OUT_W),
      .SEL_W (SEL_W)
   ) u_dec (
      .sel_i    (mem_data_i),
      .onehot_o (dec_oh)
   );

   assign len_eff  = (length_i > MAX_LEN) ? MAX_LEN : length_i;

   // Counter runs load..0 inclusive, so a period of P cycles loads P-1.
   assign on_load  = (on_q  == 32'd0) ? 32'd0 : on_q  - 32'd1;
   assign off_load = (off_q == 32'd0) ? 32'd0 : off_q - 32'd1;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         on_q    <= '0;
         off_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         on_q    <= on_d;
         off_q   <= off_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         led_q   <= led_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      on_d    = on_q;
      off_d   = off_q;
      idx_d   = idx_q;
      len_d   = len_q;
      led_d   = led_q;

      case (state_q)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               len_d   = len_eff;
               on_d    = period_f(32'(ON_CYC),  32'(level_i), 32'(DEC_CYC), 32'(MIN_CYC));
               off_d   = period_f(32'(OFF_CYC), 32'(level_i), 32'(DEC_CYC), 32'(MIN_CYC));
               idx_d   = '0;
               state_d = (len_eff == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            led_d   = dec_oh;
            cnt_d   = on_load;
            state_d = S_ON;
         end
         S_ON: begin
            if (cnt_q == 32'd0) begin
               led_d   = '0;
               cnt_d   = off_load;
               state_d = S_OFF;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_OFF: begin
            if (cnt_q == 32'd0) begin
               if ((idx_q + (ADDR_W+1)'(1)) == len_q) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + (ADDR_W+1)'(1);
                  state_d = S_FETCH;
               end
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_DONE: begin
            idx_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort overrides every transition and leaves no done pulse behind.
      if (abort_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         led_d   = '0;
         idx_d   = '0;
         cnt_d   = '0;
      end
   end

   assign mem_rd_o   = (state_q == S_FETCH);
   assign mem_addr_o = idx_q[ADDR_W-1:0];
   assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done_o     = (state_q == S_DONE);
   assign step_o     = idx_q;
   assign led_out_o  = led_q;

endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player: per-cycle comparison against a timeline model.
module tb_seq_player;

   localparam int N_CH   = 4;
   localparam int ADDR_W = 4;
   localparam int LVL_W  = 4;
   localparam int OUT_W  = 10;
   localparam int SEL_W  = 3;
   localparam int ON_C   = 4;
   localparam int OFF_C  = 3;
   localparam int DEC_C  = 1;
   localparam int MIN_C  = 2;
   localparam int MAXST  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic [ADDR_W:0]   length = '0;
   logic [LVL_W-1:0]  level = '0;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [SEL_W-1:0]  mem_data = '0;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   step;
   logic [OUT_W-1:0]  led_out;

   logic [SEL_W-1:0]  mem [MAXST];

   int passed = 0;
   int total  = 0;

   typedef struct packed {
      logic [OUT_W-1:0]  led;
      logic              busy;
      logic              done;
      logic              rd;
      logic [ADDR_W:0]   step;
      logic [ADDR_W-1:0] addr;
   } obs_t;

   obs_t exp_q[$];

   seq_player #(
      .N_CH    (N_CH),
      .ADDR_W  (ADDR_W),
      .LVL_W   (LVL_W),
      .OUT_W   (OUT_W),
      .ON_CYC  (ON_C),
      .OFF_CYC (OFF_C),
      .DEC_CYC (DEC_C),
      .MIN_CYC (MIN_C),
      .SEL_W   (SEL_W)
   ) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .start_i    (start),
      .abort_i    (abort),
      .length_i   (length),
      .level_i    (level),
      .mem_rd_o   (mem_rd),
      .mem_addr_o (mem_addr),
      .mem_data_i (mem_data),
      .busy_o     (busy),
      .done_o     (done),
      .step_o     (step),
      .led_out_o  (led_out)
   );

   always #5 clk = ~clk;

   // Sequence memory: data valid the cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd) mem_data <= mem[mem_addr];
   end

   function automatic int period_len(input int base, input int lvl);
      int p;
      p = base - lvl * DEC_C;
      return (p < MIN_C) ? MIN_C : p;
   endfunction

   function automatic logic [OUT_W-1:0] led_for(input int v);
      logic [OUT_W-1:0] r;
      r = '0;
      if (v < N_CH) r[v] = 1'b1;
      return r;
   endfunction

   function automatic obs_t mk(input logic [OUT_W-1:0] l, input logic b, input logic d,
                               input logic r, input int st);
      obs_t o;
      o.led  = l;
      o.busy = b;
      o.done = d;
      o.rd   = r;
      o.step = st[ADDR_W:0];
      o.addr = st[ADDR_W-1:0];
      return o;
   endfunction

   task automatic check(input obs_t e, input string tag);
      obs_t o;
      o.led  = led_out;
      o.busy = busy;
      o.done = done;
      o.rd   = mem_rd;
      o.step = step;
      o.addr = mem_addr;
      total++;
      assert (o === e) passed++;
      else $error("FAIL %s: got led=%b busy=%b done=%b rd=%b step=%0d addr=%0d, expected led=%b busy=%b done=%b rd=%b step=%0d addr=%0d",
                  tag, o.led, o.busy, o.done, o.rd, o.step, o.addr,
                  e.led, e.busy, e.done, e.rd, e.step, e.addr);
   endtask

   // Expected per-cycle outputs starting with the cycle after the start edge.
   task automatic build(input int len, input int lvl);
      int eff, on_l, off_l;
      eff   = (len > MAXST) ? MAXST : len;
      on_l  = period_len(ON_C, lvl);
      off_l = period_len(OFF_C, lvl);
      exp_q.delete();
      for (int i = 0; i < eff; i++) begin
         exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b1, i));
         exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b0, i));
         for (int c = 0; c < on_l; c++)  exp_q.push_back(mk(led_for(int'(mem[i])), 1'b1, 1'b0, 1'b0, i));
         for (int c = 0; c < off_l; c++) exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b0, i));
      end
      exp_q.push_back(mk('0, 1'b0, 1'b1, 1'b0, (eff == 0) ? 0 : eff - 1));
      for (int c = 0; c < 3; c++) exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 0));
   endtask

   task automatic run_seq(input int len, input int lvl, input int poke, input int abort_at,
                          input string tag);
      build(len, lvl);
      length = len[ADDR_W:0];
      level  = lvl[LVL_W-1:0];
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      for (int j = 0; j < exp_q.size(); j++) begin
         check(exp_q[j], $sformatf("%s c%0d", tag, j));
         if (j == abort_at) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            for (int m = 0; m < 3; m++) begin
               check(mk('0, 1'b0, 1'b0, 1'b0, 0), $sformatf("%s post_abort%0d", tag, m));
               @(posedge clk); #1;
            end
            return;
         end
         if (j == poke) begin
            start  = 1'b1;
            length = ADDR_W'($urandom_range(0, 31));
            level  = LVL_W'($urandom_range(0, 15));
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < MAXST; i++) mem[i] = '0;

      #1 reset = 1'b1;
      #2 check(mk('0, 1'b0, 1'b0, 1'b0, 0), "reset");
      #10 reset = 1'b0;
      @(posedge clk); #1;
      check(mk('0, 1'b0, 1'b0, 1'b0, 0), "idle_after_reset");

      mem[0] = 3'd2; mem[1] = 3'd0; mem[2] = 3'd3;
      run_seq(3, 0, -1, -1, "t1_basic");
      run_seq(0, 0, -1, -1, "t2_len0");
      run_seq(2, 5, -1, -1, "t3_lvl5");
      run_seq(2, 1, -1, -1, "t3_lvl1");

      run_seq(3, 0, -1, 11, "t4_abort");
      run_seq(3, 0, -1, -1, "t4_replay");

      start = 1'b1; abort = 1'b1; length = 5'd3;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      for (int m = 0; m < 3; m++) begin
         check(mk('0, 1'b0, 1'b0, 1'b0, 0), $sformatf("abort_start_idle%0d", m));
         @(posedge clk); #1;
      end

      length = 5'd3; level = '0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      check(mk('0, 1'b1, 1'b0, 1'b0, 0), "t5_in_off");
      #2 reset = 1'b1;
      #1 check(mk('0, 1'b0, 1'b0, 1'b0, 0), "t5_async_reset");
      #2 reset = 1'b0;
      for (int m = 0; m < 4; m++) begin
         @(posedge clk); #1;
         check(mk('0, 1'b0, 1'b0, 1'b0, 0), $sformatf("t5_idle%0d", m));
      end

      for (int i = 3; i < MAXST; i++) mem[i] = SEL_W'($urandom_range(0, 3));
      mem[3] = 3'd5;
      run_seq(20, 0, 5, -1, "t6_len20");

      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < MAXST; i++) mem[i] = SEL_W'($urandom_range(0, 5));
         run_seq($urandom_range(0, 17), $urandom_range(0, 6), 3, -1, $sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
